// File: rtl/cpu_types_pkg.sv
// Shared types for the branch-prediction controller: 2-bit counter
// encoding, controller FSM states and a few sizing constants.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bpred_cnt_t;

   typedef enum logic {
      NORMAL = 1'b0,
      FLUSH  = 1'b1
   } bpred_state_t;

   // Wide enough for FLUSH_CYCLES-1 with FLUSH_CYCLES up to 15.
   localparam int FLUSH_CNT_W = 4;

   localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/bpred_sat_counter.sv
// Next-value logic for one 2-bit saturating branch counter.
// Taken moves toward ST, untaken toward SNT; both ends stick.
module bpred_sat_counter
   import cpu_types_pkg::*;
(
   input  bpred_cnt_t cur,
   input  logic       taken,
   output bpred_cnt_t nxt
);

   // Saturating increment/decrement of the counter value.
   always_comb begin
      nxt = cur;
      if (taken) begin
         if (cur != ST) nxt = bpred_cnt_t'(2'(cur) + 2'd1);
      end else begin
         if (cur != SNT) nxt = bpred_cnt_t'(2'(cur) - 2'd1);
      end
   end

endmodule

// File: rtl/bpred_ctrl.sv
// Branch-prediction controller. Holds a PC-indexed table of 2-bit
// saturating counters, answers fetch lookups combinationally, trains
// the table on resolve, and sequences a pipeline flush of FLUSH_CYCLES
// cycles after each mispredict. Resolves seen during the flush are
// wrong-path and ignored.
// Optional build macro BPRED_STATS_EN adds branch/mispredict counters.
// FLUSH_CYCLES must lie in 1..15.
module bpred_ctrl
   import cpu_types_pkg::*;
#(
   parameter int IDX_W        = 4,
   parameter int FLUSH_CYCLES = 1
)
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             lookup_en,
   input  word_t            lookup_pc,
   output logic             decision,
   output logic [IDX_W-1:0] lookup_idx,
   input  logic             resolve_valid,
   input  logic [IDX_W-1:0] resolve_idx,
   input  logic             resolve_taken,
   input  logic             resolve_predicted,
   output logic             wrong_decision,
   output logic             predictor_flush,
   output logic             recovering
`ifdef BPRED_STATS_EN
   ,
   output logic [31:0]      stat_branches,
   output logic [31:0]      stat_mispredicts
`endif
);

   localparam int ENTRIES = 2 ** IDX_W;

   bpred_cnt_t              tbl [ENTRIES];
   bpred_state_t            state;
   bpred_state_t            state_next;
   logic [FLUSH_CNT_W-1:0]  flush_cnt;
   logic [FLUSH_CNT_W-1:0]  flush_cnt_next;
   logic                    update_en;
   logic                    mispredict;
   bpred_cnt_t              upd_cur;
   bpred_cnt_t              upd_next;
   logic                    unused_pc_bits;

   // Word-aligned PCs: the two low bits never vary, upper bits alias.
   assign lookup_idx     = lookup_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

   assign upd_cur = tbl[resolve_idx];

   bpred_sat_counter u_sat (
      .cur   (upd_cur),
      .taken (resolve_taken),
      .nxt   (upd_next)
   );

   // Next-state, flush countdown and combinational outputs.
   always_comb begin
      state_next      = state;
      flush_cnt_next  = flush_cnt;
      update_en       = 1'b0;
      mispredict      = 1'b0;
      decision        = 1'b0;
      predictor_flush = 1'b0;
      recovering      = 1'b0;
      case (state)
         NORMAL: begin
            decision   = lookup_en && tbl[lookup_idx][1];
            update_en  = resolve_valid;
            mispredict = resolve_valid && (resolve_taken != resolve_predicted);
            if (mispredict) begin
               state_next     = FLUSH;
               flush_cnt_next = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            predictor_flush = 1'b1;
            recovering      = 1'b1;
            if (flush_cnt == '0) begin
               state_next = NORMAL;
            end else begin
               flush_cnt_next = flush_cnt - FLUSH_CNT_W'(1);
            end
         end
         default: begin
            state_next = NORMAL;
         end
      endcase
   end

   // FSM state, flush counter and the one-cycle mispredict pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= NORMAL;
         flush_cnt      <= '0;
         wrong_decision <= 1'b0;
      end else begin
         state          <= state_next;
         flush_cnt      <= flush_cnt_next;
         wrong_decision <= mispredict;
      end
   end

   // Counter table: reset to weakly-not-taken, trained on accepted resolves.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < ENTRIES; i++) tbl[i] <= WNT;
      end else if (update_en) begin
         tbl[resolve_idx] <= upd_next;
      end
   end

`ifdef BPRED_STATS_EN
   // Saturating event counters for accepted branches and mispredicts.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (update_en && stat_branches != STAT_MAX)
            stat_branches <= stat_branches + 32'd1;
         if (mispredict && stat_mispredicts != STAT_MAX)
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bpred_ctrl.sv
// Self-checking bench for bpred_ctrl (FLUSH_CYCLES=3). A behavioural
// model tracks counter values as integers and the flush as a count of
// remaining cycles; every cycle the DUT outputs are compared to it.
// Honours BPRED_STATS_EN when defined.
module tb_bpred_ctrl;

   localparam int FC = 3;

   logic        CLK;
   logic        RST;
   logic        lookup_en;
   logic [31:0] lookup_pc;
   logic        decision;
   logic [3:0]  lookup_idx;
   logic        resolve_valid;
   logic [3:0]  resolve_idx;
   logic        resolve_taken;
   logic        resolve_predicted;
   logic        wrong_decision;
   logic        predictor_flush;
   logic        recovering;
`ifdef BPRED_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   int checks = 0;
   int errors = 0;

   int          mdl_ctr [16];
   int          mdl_flush_left;
   bit          mdl_wd;
   logic [31:0] mdl_branches;
   logic [31:0] mdl_mispredicts;

   bpred_ctrl #(.IDX_W(4), .FLUSH_CYCLES(FC)) dut (
      .CLK               (CLK),
      .RST               (RST),
      .lookup_en         (lookup_en),
      .lookup_pc         (lookup_pc),
      .decision          (decision),
      .lookup_idx        (lookup_idx),
      .resolve_valid     (resolve_valid),
      .resolve_idx       (resolve_idx),
      .resolve_taken     (resolve_taken),
      .resolve_predicted (resolve_predicted),
      .wrong_decision    (wrong_decision),
      .predictor_flush   (predictor_flush),
      .recovering        (recovering)
`ifdef BPRED_STATS_EN
      ,
      .stat_branches     (stat_branches),
      .stat_mispredicts  (stat_mispredicts)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model update on a clock edge, from the rules of the controller.
   task automatic modelStep();
      int i;
      if (RST) begin
         for (int k = 0; k < 16; k++) mdl_ctr[k] = 1;
         mdl_flush_left  = 0;
         mdl_wd          = 0;
         mdl_branches    = 0;
         mdl_mispredicts = 0;
      end else if (mdl_flush_left > 0) begin
         mdl_flush_left--;
         mdl_wd = 0;
      end else begin
         mdl_wd = 0;
         if (resolve_valid) begin
            i = int'(resolve_idx);
            if (resolve_taken) mdl_ctr[i] = (mdl_ctr[i] >= 3) ? 3 : mdl_ctr[i] + 1;
            else               mdl_ctr[i] = (mdl_ctr[i] <= 0) ? 0 : mdl_ctr[i] - 1;
            if (mdl_branches != 32'hFFFF_FFFF) mdl_branches++;
            if (resolve_taken != resolve_predicted) begin
               mdl_wd         = 1;
               mdl_flush_left = FC;
               if (mdl_mispredicts != 32'hFFFF_FFFF) mdl_mispredicts++;
            end
         end
      end
   endtask

   // Compare all outputs against the model mid-cycle.
   task automatic checkOutput();
      int  idx;
      bit  exp_dec;
      idx     = int'((lookup_pc / 4) % 16);
      exp_dec = lookup_en && (mdl_flush_left == 0) && (mdl_ctr[idx] >= 2);
      checkVal("decision", {31'b0, decision}, {31'b0, exp_dec});
      checkVal("lookup_idx", {28'b0, lookup_idx}, idx);
      checkVal("wrong_decision", {31'b0, wrong_decision}, {31'b0, mdl_wd});
      checkVal("predictor_flush", {31'b0, predictor_flush}, {31'b0, mdl_flush_left > 0});
      checkVal("recovering", {31'b0, recovering}, {31'b0, mdl_flush_left > 0});
`ifdef BPRED_STATS_EN
      checkVal("stat_branches", stat_branches, mdl_branches);
      checkVal("stat_mispredicts", stat_mispredicts, mdl_mispredicts);
`endif
   endtask

   // Drive one cycle's inputs and check outputs at the falling edge.
   task automatic applyStimulus(input logic rst, input logic en, input logic [31:0] pc,
                                input logic rv, input logic [3:0] ridx,
                                input logic taken, input logic pred);
      RST               = rst;
      lookup_en         = en;
      lookup_pc         = pc;
      resolve_valid     = rv;
      resolve_idx       = ridx;
      resolve_taken     = taken;
      resolve_predicted = pred;
      @(negedge CLK);
      checkOutput();
   endtask

   task automatic tick();
      @(posedge CLK);
      modelStep();
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 32'h0, 0, 4'h0, 0, 0);
      tick();
   endtask

   task automatic resolveCycle(input logic [3:0] ridx, input logic taken, input logic pred);
      applyStimulus(0, 0, 32'h0, 1, ridx, taken, pred);
      tick();
   endtask

   initial begin
      int accepted;
      int budget;

      RST = 1; lookup_en = 0; lookup_pc = 0;
      resolve_valid = 0; resolve_idx = 0; resolve_taken = 0; resolve_predicted = 0;
      tick();
      tick();

      $display("[TB] reset state");
      applyStimulus(0, 1, 32'h0000_0040, 0, 4'h0, 0, 0);
      checkVal("reset_idx_0x40", {28'b0, lookup_idx}, 32'h0);
      checkVal("reset_decision_0x40", {31'b0, decision}, 32'h0);
      tick();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 1, 32'(i * 4), 0, 4'h0, 0, 0);
         checkVal("reset_entry_wnt", {31'b0, decision}, 32'h0);
         tick();
      end

      $display("[TB] mispredict then training idx 0");
      resolveCycle(4'h0, 1, 0);
      applyStimulus(0, 1, 32'h0000_0040, 0, 4'h0, 0, 0);
      checkVal("wd_pulse", {31'b0, wrong_decision}, 32'h1);
      checkVal("flush_c1", {31'b0, predictor_flush}, 32'h1);
      checkVal("dec_forced0", {31'b0, decision}, 32'h0);
      tick();
      applyStimulus(0, 1, 32'h0000_0040, 1, 4'h0, 0, 1);
      checkVal("wd_once", {31'b0, wrong_decision}, 32'h0);
      checkVal("flush_c2", {31'b0, predictor_flush}, 32'h1);
      tick();
      applyStimulus(0, 0, 32'h0, 0, 4'h0, 0, 0);
      checkVal("flush_c3", {31'b0, predictor_flush}, 32'h1);
      tick();
      applyStimulus(0, 1, 32'h0000_0040, 0, 4'h0, 0, 0);
      checkVal("flush_done", {31'b0, predictor_flush}, 32'h0);
      checkVal("wrongpath_ignored", {31'b0, decision}, 32'h1);
      tick();
      resolveCycle(4'h0, 1, 1);
      resolveCycle(4'h0, 1, 1);
      for (int i = 0; i < 4; i++) resolveCycle(4'h0, 1, 1);
      resolveCycle(4'h0, 0, 1);
      for (int i = 0; i < FC; i++) idle();
      applyStimulus(0, 1, 32'h0000_0040, 0, 4'h0, 0, 0);
      checkVal("st_no_overflow", {31'b0, decision}, 32'h1);
      tick();

      $display("[TB] same-cycle lookup and update idx 5");
      applyStimulus(0, 1, 32'h0000_0014, 1, 4'h5, 1, 1);
      checkVal("no_bypass", {31'b0, decision}, 32'h0);
      tick();
      applyStimulus(0, 1, 32'h0000_0014, 0, 4'h0, 0, 0);
      checkVal("update_visible", {31'b0, decision}, 32'h1);
      tick();

      $display("[TB] reset during flush");
      resolveCycle(4'h7, 1, 0);
      idle();
      applyStimulus(1, 0, 32'h0, 1, 4'h7, 1, 1);
      checkVal("flush_before_rst", {31'b0, predictor_flush}, 32'h1);
      tick();
      applyStimulus(0, 1, 32'h0000_001C, 0, 4'h0, 0, 0);
      checkVal("rst_abort_flush", {31'b0, predictor_flush}, 32'h0);
      checkVal("rst_abort_recov", {31'b0, recovering}, 32'h0);
      checkVal("rst_entry_wnt", {31'b0, decision}, 32'h0);
      tick();

      $display("[TB] randomized traffic");
      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(63) == 0), 1'($urandom), $urandom,
                       ($urandom_range(2) != 0), 4'($urandom), 1'($urandom),
                       ($urandom_range(3) == 0) ? 1'($urandom) : 1'($urandom_range(1)));
         tick();
      end

      $display("[TB] statistics run");
      applyStimulus(1, 0, 32'h0, 0, 4'h0, 0, 0);
      tick();
      accepted = 0;
      budget   = 200;
      while (accepted < 10 && budget > 0) begin
         if (mdl_flush_left == 0) begin
            applyStimulus(0, 0, 32'h0, 1, 4'($urandom), 1,
                          (accepted == 2 || accepted == 5 || accepted == 8) ? 1'b0 : 1'b1);
            accepted++;
         end else begin
            applyStimulus(0, 0, 32'h0, 1, 4'($urandom), 1, 0);
         end
         tick();
         budget--;
      end
      checkVal("stats_budget", accepted, 10);
      idle();
`ifdef BPRED_STATS_EN
      applyStimulus(0, 0, 32'h0, 0, 4'h0, 0, 0);
      checkVal("stat_branches_10", stat_branches, 32'd10);
      checkVal("stat_mispredicts_3", stat_mispredicts, 32'd3);
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
